// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache/dcache request channels and the shared memory channel.
// master: the arbiter side. slave: the environment (caches + memory).
interface cache_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
);
   // icache refill path
   logic              ic_req_valid;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_req_ready;
   logic              ic_rdata_valid;
   // dcache refill/writeback path
   logic              dc_req_valid;
   logic              dc_req_rnw;
   logic [ADDR_W-1:0] dc_req_addr;
   logic              dc_req_ready;
   logic              dc_wdata_valid;
   logic [DATA_W-1:0] dc_wdata;
   logic              dc_wdata_ready;
   logic              dc_rdata_valid;
   logic [DATA_W-1:0] rdata;
   // memory channel
   logic              mem_cmd_valid;
   logic              mem_cmd_ready;
   logic              mem_cmd_rnw;
   logic [ADDR_W-1:0] mem_cmd_addr;
   logic              mem_wdata_valid;
   logic              mem_wdata_ready;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rdata_valid;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport master (
      input  ic_req_valid, ic_req_addr,
      output ic_req_ready, ic_rdata_valid,
      input  dc_req_valid, dc_req_rnw, dc_req_addr, dc_wdata_valid, dc_wdata,
      output dc_req_ready, dc_wdata_ready, dc_rdata_valid, rdata,
      output mem_cmd_valid, mem_cmd_rnw, mem_cmd_addr, mem_wdata_valid, mem_wdata,
      input  mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata,
      output busy
   );

   modport slave (
      output ic_req_valid, ic_req_addr,
      input  ic_req_ready, ic_rdata_valid,
      output dc_req_valid, dc_req_rnw, dc_req_addr, dc_wdata_valid, dc_wdata,
      input  dc_req_ready, dc_wdata_ready, dc_rdata_valid, rdata,
      input  mem_cmd_valid, mem_cmd_rnw, mem_cmd_addr, mem_wdata_valid, mem_wdata,
      output mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata,
      input  busy
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one memory request channel between icache refill and
// dcache refill/writeback. A grant covers one command plus BEATS data beats.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed
// dcache priority.
module cache_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned BEATS  = 2
) (
   input logic                 clk,
   input logic                 rst,
   cache_mem_arbiter_if.master bus
);

   localparam int unsigned CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;
   typedef enum logic {GntIc, GntDc} grant_e;

   state_e            state_q, state_d;
   grant_e            grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rnw_q, rnw_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              pick_dc;

`ifdef ARB_ROUND_ROBIN_EN
   grant_e last_grant_q, last_grant_d;

   // Tie goes to whoever was not granted last time.
   assign pick_dc = bus.dc_req_valid & (~bus.ic_req_valid | (last_grant_q == GntIc));

   // Last-grant history for round-robin tie-breaking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_grant_q <= GntIc;
      else     last_grant_q <= last_grant_d;
   end
`else
   // Fixed priority: dcache always wins.
   assign pick_dc = bus.dc_req_valid;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Transaction context latched at grant time, plus the beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q <= GntIc;
         addr_q  <= '0;
         rnw_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         grant_q <= grant_d;
         addr_q  <= addr_d;
         rnw_q   <= rnw_d;
         beat_q  <= beat_d;
      end
   end

   // Next-state: arbitration in idle, then command, then BEATS data beats.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      rnw_d   = rnw_q;
      beat_d  = beat_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.ic_req_valid || bus.dc_req_valid) begin
               state_d = StCmd;
               beat_d  = '0;
               if (pick_dc) begin
                  grant_d = GntDc;
                  addr_d  = bus.dc_req_addr;
                  rnw_d   = bus.dc_req_rnw;
               end else begin
                  grant_d = GntIc;
                  addr_d  = bus.ic_req_addr;
                  rnw_d   = 1'b1;  // icache only ever reads
               end
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = pick_dc ? GntDc : GntIc;
`endif
            end
         end
         StCmd: begin
            if (bus.mem_cmd_ready) state_d = rnw_q ? StRdata : StWdata;
         end
         StWdata: begin
            if (bus.dc_wdata_valid && bus.mem_wdata_ready) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = StIdle;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
         end
         StRdata: begin
            if (bus.mem_rdata_valid) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = StIdle;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state; data paths are zeroed outside their phase so
   // everything reads 0 in idle and while reset is held.
   always_comb begin
      bus.ic_req_ready    = 1'b0;
      bus.dc_req_ready    = 1'b0;
      bus.ic_rdata_valid  = 1'b0;
      bus.dc_rdata_valid  = 1'b0;
      bus.dc_wdata_ready  = 1'b0;
      bus.rdata           = '0;
      bus.mem_cmd_valid   = 1'b0;
      bus.mem_cmd_rnw     = 1'b0;
      bus.mem_cmd_addr    = '0;
      bus.mem_wdata_valid = 1'b0;
      bus.mem_wdata       = '0;
      bus.busy            = (state_q != StIdle);
      unique case (state_q)
         StIdle: ;
         StCmd: begin
            bus.mem_cmd_valid = 1'b1;
            bus.mem_cmd_rnw   = rnw_q;
            bus.mem_cmd_addr  = addr_q;
            bus.ic_req_ready  = bus.mem_cmd_ready & (grant_q == GntIc);
            bus.dc_req_ready  = bus.mem_cmd_ready & (grant_q == GntDc);
         end
         StWdata: begin
            bus.mem_wdata_valid = bus.dc_wdata_valid;
            bus.mem_wdata       = bus.dc_wdata;
            bus.dc_wdata_ready  = bus.mem_wdata_ready;
         end
         StRdata: begin
            bus.rdata          = bus.mem_rdata;
            bus.ic_rdata_valid = bus.mem_rdata_valid & (grant_q == GntIc);
            bus.dc_rdata_valid = bus.mem_rdata_valid & (grant_q == GntDc);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter (BEATS = 2).
module tb_cache_mem_arbiter;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;

   cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(128)) bus ();

   cache_mem_arbiter #(.ADDR_W(32), .DATA_W(128), .BEATS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected read beats, pushed when a command is accepted.
   typedef struct {
      logic         to_dc;
      logic [127:0] data;
   } rd_exp_t;
   rd_exp_t rq[$];

   typedef struct {
      logic         is_dc;
      logic         rnw;
      logic [31:0]  addr;
      int           cmd_stall;
      int           data_stall;
      logic [127:0] d0;
      logic [127:0] d1;
      logic         exp_rnw;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ic_req_valid    = 1'b0;
      bus.ic_req_addr     = '0;
      bus.dc_req_valid    = 1'b0;
      bus.dc_req_rnw      = 1'b0;
      bus.dc_req_addr     = '0;
      bus.dc_wdata_valid  = 1'b0;
      bus.dc_wdata        = '0;
      bus.mem_cmd_ready   = 1'b0;
      bus.mem_wdata_ready = 1'b0;
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata       = '0;
   endtask

   task automatic push_reads(input logic to_dc, input logic [127:0] d0, input logic [127:0] d1);
      rd_exp_t e;
      e.to_dc = to_dc;
      e.data  = d0;
      rq.push_back(e);
      e.data  = d1;
      rq.push_back(e);
   endtask

   // Drive one memory read beat and check it against the scoreboard head.
   task automatic read_beat(input logic [127:0] d);
      rd_exp_t e;
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = d;
      #1;
      check("sb_nonempty", 128'(rq.size() != 0), 128'(1));
      if (rq.size() != 0) begin
         e = rq.pop_front();
         check("rd_route", {bus.ic_rdata_valid, bus.dc_rdata_valid}, e.to_dc ? 2'b01 : 2'b10);
         check("rdata", bus.rdata, e.data);
      end
      check("rd_busy", bus.busy, 1'b1);
   endtask

   task automatic run_txn(input vec_t v);
      logic [1:0] exp_rdy;
      exp_rdy = v.is_dc ? 2'b01 : 2'b10;
      check("idle_busy", bus.busy, 1'b0);
      bus.ic_req_valid = ~v.is_dc;
      bus.ic_req_addr  = v.addr;
      bus.dc_req_valid = v.is_dc;
      bus.dc_req_rnw   = v.rnw;
      bus.dc_req_addr  = v.addr;
      tick();
      for (int i = 0; i < v.cmd_stall; i++) begin
         check("cmd_valid_stall", bus.mem_cmd_valid, 1'b1);
         check("cmd_addr_stable", bus.mem_cmd_addr, v.addr);
         check("req_ready_stall", {bus.ic_req_ready, bus.dc_req_ready}, 2'b00);
         tick();
      end
      bus.mem_cmd_ready = 1'b1;
      #1;
      check("cmd_valid", bus.mem_cmd_valid, 1'b1);
      check("cmd_addr", bus.mem_cmd_addr, v.addr);
      check("cmd_rnw", bus.mem_cmd_rnw, v.exp_rnw);
      check("req_ready", {bus.ic_req_ready, bus.dc_req_ready}, exp_rdy);
      if (v.exp_rnw) push_reads(v.is_dc, v.d0, v.d1);
      tick();
      bus.ic_req_valid  = 1'b0;
      bus.dc_req_valid  = 1'b0;
      bus.mem_cmd_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < v.data_stall; s++) begin
            if (v.exp_rnw) begin
               bus.mem_rdata_valid = 1'b0;
               #1;
               check("rd_stall_valid", {bus.ic_rdata_valid, bus.dc_rdata_valid}, 2'b00);
            end else begin
               bus.dc_wdata_valid  = 1'b1;
               bus.dc_wdata        = (b == 0) ? v.d0 : v.d1;
               bus.mem_wdata_ready = 1'b0;
               #1;
               check("wr_stall_valid", bus.mem_wdata_valid, 1'b1);
               check("wr_stall_ready", bus.dc_wdata_ready, 1'b0);
            end
            check("stall_busy", bus.busy, 1'b1);
            tick();
         end
         if (v.exp_rnw) begin
            read_beat((b == 0) ? v.d0 : v.d1);
         end else begin
            bus.dc_wdata_valid  = 1'b1;
            bus.dc_wdata        = (b == 0) ? v.d0 : v.d1;
            bus.mem_wdata_ready = 1'b1;
            #1;
            check("wr_valid", bus.mem_wdata_valid, 1'b1);
            check("wr_ready", bus.dc_wdata_ready, 1'b1);
            check("wr_data", bus.mem_wdata, (b == 0) ? v.d0 : v.d1);
            check("wr_busy", bus.busy, 1'b1);
         end
         tick();
      end
      clear_inputs();
      check("done_busy", bus.busy, 1'b0);
      check("sb_drained", 128'(rq.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_dc[6];
      n_vec  = 0;
      n_fail = 0;

      vecs[0] = '{1'b0, 1'b1, 32'h1000_0040, 0, 0,
                  128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA,
                  128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 32'h3000_0000, 0, 3,
                  128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                  128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h2000_1000, 10, 1,
                  128'hC0C0_0000_0000_0000_0000_0000_0000_0001,
                  128'hD0D0_0000_0000_0000_0000_0000_0000_0002, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 32'h1000_0080, 2, 2,  // icache rnw input ignored
                  128'h1111_0000_0000_0000_0000_0000_0000_0011,
                  128'h2222_0000_0000_0000_0000_0000_0000_0022, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 32'h3000_0040, 1, 0,
                  128'h5555_5555_0000_0000_0000_0000_5555_5555,
                  128'h6666_6666_0000_0000_0000_0000_6666_6666, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 32'h1000_0100, 0, 0,
                  128'hE1E1_0000_0000_0000_0000_0000_0000_00E1,
                  128'hE2E2_0000_0000_0000_0000_0000_0000_00E2, 1'b1};

`ifdef ARB_ROUND_ROBIN_EN
      exp_dc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_dc = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

      // Reset state
      rst = 1'b1;
      clear_inputs();
      #2;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_cmd_valid", bus.mem_cmd_valid, 1'b0);
      check("rst_ready", {bus.ic_req_ready, bus.dc_req_ready, bus.dc_wdata_ready}, 3'b000);
      check("rst_rvalid", {bus.ic_rdata_valid, bus.dc_rdata_valid}, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Arbitration with both requesters holding valid from reset
      bus.ic_req_valid = 1'b1;
      bus.ic_req_addr  = 32'h1000_0200;
      bus.dc_req_valid = 1'b1;
      bus.dc_req_rnw   = 1'b1;
      bus.dc_req_addr  = 32'h2000_0200;
      for (int i = 0; i < 6; i++) begin
         check("arb_idle_gap", bus.busy, 1'b0);
         tick();
         check("arb_cmd_valid", bus.mem_cmd_valid, 1'b1);
         bus.mem_cmd_ready = 1'b1;
         #1;
         check("arb_grant", {bus.ic_req_ready, bus.dc_req_ready}, exp_dc[i] ? 2'b01 : 2'b10);
         check("arb_addr", bus.mem_cmd_addr, exp_dc[i] ? 32'h2000_0200 : 32'h1000_0200);
         push_reads(exp_dc[i], 128'(i * 2 + 100), 128'(i * 2 + 101));
`ifndef ARB_ROUND_ROBIN_EN
         if (i == 2) bus.dc_req_valid = 1'b0;
`endif
         tick();
         bus.mem_cmd_ready = 1'b0;
         read_beat(128'(i * 2 + 100));
         tick();
         read_beat(128'(i * 2 + 101));
         tick();
         bus.mem_rdata_valid = 1'b0;
      end
      clear_inputs();
      check("arb_sb_drained", 128'(rq.size()), 128'(0));
      tick();

      // Table-driven transactions
      for (int k = 0; k < 5; k++) run_txn(vecs[k]);

      // Spurious read beats in idle are ignored
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = 128'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("spur_rvalid", {bus.ic_rdata_valid, bus.dc_rdata_valid}, 2'b00);
         check("spur_busy", bus.busy, 1'b0);
         tick();
      end
      clear_inputs();
      run_txn(vecs[5]);  // full two beats => counter was still 0

      // Reset during RDATA after one beat
      bus.ic_req_valid = 1'b1;
      bus.ic_req_addr  = 32'h1000_0300;
      tick();
      bus.mem_cmd_ready = 1'b1;
      push_reads(1'b0, 128'h77, 128'h88);
      tick();
      clear_inputs();
      read_beat(128'h77);
      tick();
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = 128'h88;
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_rvalid", {bus.ic_rdata_valid, bus.dc_rdata_valid}, 2'b00);
      check("rst_mid_busy", bus.busy, 1'b0);
      check("rst_mid_rdata", bus.rdata, 128'h0);
      rq.delete();
      tick();
      rst = 1'b0;
      clear_inputs();
      tick();
      run_txn(vecs[0]);  // must again take two full beats

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
